// File: rtl/servo_pulse_decoder_pkg.sv
// Shared servo timing constants and the width-to-position mapping used by the
// servo generator and the pulse decoder.
package servo_pulse_decoder_pkg;

  localparam int unsigned SERVO_FRAME_HZ = 50;
  localparam int unsigned DUTY_MIN_PCT   = 5;
  localparam int unsigned DUTY_MAX_PCT   = 10;
  localparam int unsigned FRAME_MIN_PCT  = 90;
  localparam int unsigned FRAME_MAX_PCT  = 110;
  localparam int unsigned TIMEOUT_MULT   = 2;

  // Linear map of pulse width onto 0..255; dmin/dmax are elaboration constants,
  // so the division reduces to a constant divide.
  function automatic logic [7:0] duty_to_position(input logic [31:0] width,
                                                  input logic [31:0] dmin,
                                                  input logic [31:0] dmax);
    if (width <= dmin) return 8'd0;
    if (width >= dmax) return 8'd255;
    return 8'(((width - dmin) * 32'd255) / (dmax - dmin));
  endfunction

endpackage

// File: rtl/servo_pulse_decoder_sync_edge.sv
// Two-flop synchronizer for the servo line plus a third copy for edge detection.
module servo_pulse_decoder_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b000;
    else        sync_q <= {sync_q[1:0], d_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo PWM frames: pulse width, frame length, mapped position,
// range check and loss-of-signal detection.
//
// state   | meaning
// IDLE    | waiting for the first rising edge of a frame
// HIGH    | line high, counting pulse width and frame length
// LOW     | line low, counting frame length until the closing rise
module servo_pulse_decoder
  import servo_pulse_decoder_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned PERIOD   = CLK_FREQ / SERVO_FRAME_HZ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [31:0] pulse_width,
  output logic [31:0] frame_len,
  output logic [7:0]  position,
  output logic        in_range,
  output logic        valid,
  output logic        signal_lost
);

  localparam logic [31:0] DUTY_MIN  = 32'(PERIOD * DUTY_MIN_PCT / 100);
  localparam logic [31:0] DUTY_MAX  = 32'(PERIOD * DUTY_MAX_PCT / 100);
  localparam logic [31:0] FRAME_MIN = 32'(PERIOD * FRAME_MIN_PCT / 100);
  localparam logic [31:0] FRAME_MAX = 32'(PERIOD * FRAME_MAX_PCT / 100);
  localparam logic [31:0] TIMEOUT   = 32'(PERIOD * TIMEOUT_MULT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic        rise, fall;
  logic [1:0]  state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] width_q, width_d;
  logic [31:0] pw_q, pw_d;
  logic [31:0] fl_q, fl_d;
  logic [7:0]  pos_q, pos_d;
  logic        inr_q, inr_d;
  logic        valid_q, valid_d;
  logic        lost_q, lost_d;

  servo_pulse_decoder_sync_edge u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    width_d = width_q;
    pw_d    = pw_q;
    fl_d    = fl_q;
    pos_d   = pos_q;
    inr_d   = inr_q;
    valid_d = 1'b0;
    lost_d  = lost_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          frame_d = 32'd1;
          width_d = 32'd1;
        end
      end
      ST_HIGH: begin
        // Timeout keeps the counters below TIMEOUT, so they can never wrap.
        if (frame_q >= TIMEOUT) begin
          state_d = ST_IDLE;
          lost_d  = 1'b1;
        end else begin
          frame_d = frame_q + 32'd1;
          if (fall) state_d = ST_LOW;
          else      width_d = width_q + 32'd1;
        end
      end
      ST_LOW: begin
        if (frame_q >= TIMEOUT) begin
          state_d = ST_IDLE;
          lost_d  = 1'b1;
        end else if (rise) begin
          state_d = ST_HIGH;
          pw_d    = width_q;
          fl_d    = frame_q;
          pos_d   = duty_to_position(width_q, DUTY_MIN, DUTY_MAX);
          inr_d   = (width_q >= DUTY_MIN) && (width_q <= DUTY_MAX) &&
                    (frame_q >= FRAME_MIN) && (frame_q <= FRAME_MAX);
          valid_d = 1'b1;
          lost_d  = 1'b0;
          frame_d = 32'd1;
          width_d = 32'd1;
        end else begin
          frame_d = frame_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      width_q <= '0;
      pw_q    <= '0;
      fl_q    <= '0;
      pos_q   <= '0;
      inr_q   <= 1'b0;
      valid_q <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      width_q <= width_d;
      pw_q    <= pw_d;
      fl_q    <= fl_d;
      pos_q   <= pos_d;
      inr_q   <= inr_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
    end
  end

  assign pulse_width = pw_q;
  assign frame_len   = fl_q;
  assign position    = pos_q;
  assign in_range    = inr_q;
  assign valid       = valid_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder with a scaled-down frame period.
`timescale 1ns/1ps
module tb_servo_pulse_decoder;

  localparam int unsigned P     = 1000;
  localparam int unsigned DMIN  = P * 5 / 100;
  localparam int unsigned DMAX  = P * 10 / 100;
  localparam int unsigned FMIN  = P * 9 / 10;
  localparam int unsigned FMAX  = P * 11 / 10;
  localparam int unsigned TOUT  = 2 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic [31:0] pulse_width, frame_len;
  logic [7:0]  position;
  logic        in_range, valid, signal_lost;

  servo_pulse_decoder #(.CLK_FREQ(50_000), .PERIOD(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .pulse_width (pulse_width),
    .frame_len   (frame_len),
    .position    (position),
    .in_range    (in_range),
    .valid       (valid),
    .signal_lost (signal_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned w;
    int unsigned p;
    int unsigned pos;
    bit          inr;
    longint      cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_e;
  longint      cyc = 0;
  int          tests = 0;
  int          failed = 0;
  bit          prev_have = 0;
  int unsigned prev_w, prev_p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned ref_pos(input int unsigned w);
    if (w <= DMIN) return 0;
    if (w >= DMAX) return 255;
    return (w - DMIN) * 255 / (DMAX - DMIN);
  endfunction

  // A rise closes the previous frame (if one is open) and opens a new one.
  task automatic model_rise(input int unsigned w, input int unsigned p);
    exp_t e;
    if (prev_have) begin
      e.w   = prev_w;
      e.p   = prev_p;
      e.pos = ref_pos(prev_w);
      e.inr = (prev_w >= DMIN) && (prev_w <= DMAX) && (prev_p >= FMIN) && (prev_p <= FMAX);
      e.cyc = cyc + 3;
      sb.push_back(e);
      last_e = e;
    end
    prev_have = 1;
    prev_w    = w;
    prev_p    = p;
  endtask

  task automatic drive_frame(input int unsigned w, input int unsigned p);
    @(negedge clk);
    pwm_in = 1'b1;
    model_rise(w, p);
    repeat (w) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - w - 1) @(negedge clk);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_signal_lost"}, signal_lost, 1);
    chk({tag, "_pulse_width"}, pulse_width, last_e.w);
    chk({tag, "_frame_len"}, frame_len, last_e.p);
    chk({tag, "_position"}, position, last_e.pos);
    chk({tag, "_in_range"}, in_range, last_e.inr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pulse_width"}, pulse_width, 0);
    chk({tag, "_frame_len"}, frame_len, 0);
    chk({tag, "_position"}, position, 0);
    chk({tag, "_in_range"}, in_range, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_signal_lost"}, signal_lost, 1);
  endtask

  // Monitor: every valid strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_valid: got valid=1 expected no valid (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency_cycle", cyc, e.cyc);
        chk("pulse_width", pulse_width, e.w);
        chk("frame_len", frame_len, e.p);
        chk("position", position, e.pos);
        chk("in_range", in_range, e.inr);
        chk("signal_lost_clear", signal_lost, 0);
      end
    end
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    repeat (3) drive_frame(75, P);
    drive_frame(50, P);
    drive_frame(100, P);
    drive_frame(120, P);
    drive_frame(20, P);
    drive_frame(75, 800);
    drive_frame(75, FMIN);
    drive_frame(75, FMAX);
    drive_frame(76, FMIN - 1);
    drive_frame(51, FMAX + 1);
    for (int i = 0; i < 10; i++)
      drive_frame($urandom_range(10, 130), $urandom_range(850, 1150));

    // Line stuck low after the last frame: partial frame is discarded.
    repeat (TOUT + 100) @(negedge clk);
    prev_have = 0;
    chk("stuck_low_pending", sb.size(), 0);
    chk_held("stuck_low");

    drive_frame(90, P);
    chk("lost_until_full_frame", signal_lost, 1);
    drive_frame(60, 950);

    // Line stuck high: the opening rise closes the previous frame, then times out.
    @(negedge clk);
    pwm_in = 1'b1;
    model_rise(0, 0);
    repeat (TOUT + 500) @(negedge clk);
    pwm_in = 1'b0;
    prev_have = 0;
    repeat (20) @(negedge clk);
    chk("stuck_high_pending", sb.size(), 0);
    chk_held("stuck_high");

    repeat (2) drive_frame(80, P);
    @(negedge clk);
    pwm_in = 1'b1;
    model_rise(0, 0);
    repeat (30) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    pwm_in    = 1'b0;
    prev_have = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_frame(70, P);
    drive_frame(85, 1050);
    drive_frame(95, P);

    @(negedge clk);
    pwm_in = 1'b1;
    model_rise(10, P);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("final_pending", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/servo_pulse_decoder.md
SERVO_PULSE_DECODER -- requirements
Module: servo_pulse_decoder

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000, clk frequency in Hz.
REQ-002 Parameter PERIOD, default 500_000, nominal servo frame length in clk cycles (20 ms at 25 MHz).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pwm_in  input  1  asynchronous servo PWM line (active-high pulse once per frame).
REQ-006 pulse_width  output  32  high time of last complete frame, in clk cycles.
REQ-007 frame_len  output  32  rise-to-rise length of last complete frame, in clk cycles.
REQ-008 position  output  8  pulse_width mapped linearly DUTY_MIN..DUTY_MAX -> 0..255, clamped.
REQ-009 in_range  output  1  last frame within servo limits (REQ-019).
REQ-010 valid  output  1  one-cycle strobe: new measurement on outputs.
REQ-011 signal_lost  output  1  no rising edge for TIMEOUT cycles.

Function
REQ-012 pwm_in SHALL pass a 2-FF synchronizer, then edge detection against a third registered copy; a rising or falling edge is detected 3 clk edges after the input transition.
REQ-013 Constants: DUTY_MIN = PERIOD*5/100 (25_000), DUTY_MAX = PERIOD*10/100 (50_000), TIMEOUT = 2*PERIOD (1_000_000).
REQ-014 FSM states: IDLE (await first rise), HIGH (line high, counting width), LOW (line low, awaiting next rise).
REQ-015 IDLE -> HIGH on detected rise; frame and width counters load 1; no valid.
REQ-016 HIGH: both counters increment each cycle; on detected fall -> LOW, width counter frozen.
REQ-017 LOW: frame counter increments; on detected rise -> HIGH, latch pulse_width = width counter, frame_len = frame counter, reload both counters to 1, assert valid.
REQ-018 valid SHALL be high exactly one cycle, the cycle after the clock edge detecting the closing rise; pulse_width, frame_len, position, in_range update on that same edge and hold until the next valid.
REQ-019 in_range = 1 iff DUTY_MIN <= width <= DUTY_MAX and PERIOD*9/10 <= frame <= PERIOD*11/10.
REQ-020 position = 0 if width <= DUTY_MIN; 255 if width >= DUTY_MAX; else floor((width-DUTY_MIN)*255/(DUTY_MAX-DUTY_MIN)); constant divisor only, no runtime divider; 32-bit intermediate minimum.
REQ-021 Timeout: in HIGH or LOW, if frame counter reaches TIMEOUT (line stuck high or low) -> IDLE, signal_lost=1, no valid, measurement outputs held.
REQ-022 signal_lost clears on the edge that asserts valid; stays 1 through IDLE->HIGH until a full frame completes.
REQ-023 Counters SHALL never wrap: timeout preempts at TIMEOUT < 2^32.
REQ-024 Fall detected in LOW or IDLE, or rise in HIGH, cannot occur (edge alternation); FSM ignores them defensively.

Reset
REQ-025 rst_n low: state=IDLE, counters, sync flops, pulse_width, frame_len, position = 0; in_range=0, valid=0, signal_lost=1.
REQ-026 Reset mid-frame SHALL discard the partial frame; first valid after release requires two detected rises.

Structure
REQ-027 DUTY_MIN/DUTY_MAX percentages, PERIOD default and TIMEOUT multiplier SHALL live in a shared servo constants package/include used by both servo and servo_pulse_decoder.
REQ-028 One sub-module: sync_edge (2-FF synchronizer + rise/fall pulse outputs); FSM, counters, mapping in top.

Verification
REQ-029 Frames 37_500 high / 500_000 period, x3 -> first valid after 2nd rise; pulse_width=37_500, frame_len=500_000, position=127, in_range=1, signal_lost 1->0.
REQ-030 width 25_000 -> position=0, in_range=1; width 50_000 -> 255, in_range=1; width 60_000 -> 255, in_range=0; width 10_000 -> 0, in_range=0.
REQ-031 Period 400_000 with width 37_500 -> in_range=0, frame_len=400_000, position=127.
REQ-032 pwm_in held low 1_000_000 cycles after a valid frame -> signal_lost=1, state IDLE, no valid; resume frames -> valid only after 2nd rise.
REQ-033 pwm_in held high > 1_000_000 cycles -> signal_lost=1, no valid, outputs unchanged.
REQ-034 rst_n pulsed low mid-HIGH -> all outputs reset values immediately (async); next valid after two full rises.
